// File: rtl/i3c_pkg.sv
// Shared I3C target types: TTI TX descriptor layout and TX descriptor FSM states.
package i3c_pkg;

    typedef struct packed {
        logic [15:0] reserved;
        logic [15:0] data_length;
    } tti_tx_desc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } tx_desc_state_e;

endpackage

// File: rtl/descriptor_tx.sv
// Target-side TX path for I3C Private Reads: pops a TX descriptor, then streams its bytes
// from the TTI TX data queue to the target FSM, draining leftovers after a controller abort.
module descriptor_tx
    import i3c_pkg::*;
#(
    parameter int TtiTxDescDataWidth = 32,
    parameter int TtiTxDataWidth     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic                          tti_tx_desc_queue_rvalid_i,
    output logic                          tti_tx_desc_queue_rready_o,
    input  logic [TtiTxDescDataWidth-1:0] tti_tx_desc_queue_rdata_i,

    input  logic                          tti_tx_queue_rvalid_i,
    output logic                          tti_tx_queue_rready_o,
    input  logic [TtiTxDataWidth-1:0]     tti_tx_queue_rdata_i,

    output logic [7:0]                    tx_byte_o,
    output logic                          tx_byte_valid_o,
    input  logic                          tx_byte_ready_i,
    output logic                          tx_byte_last_o,
    output logic                          tx_byte_err_o,
    input  logic                          tx_abort_i,
    output logic                          tx_data_pending_o,
    output logic                          tx_done_o
);

    tx_desc_state_e state_q, state_d;
    logic [15:0]    remaining_q, remaining_d;
    logic           done_q, done_d;

    tti_tx_desc_t   desc;
    logic           unused_desc_reserved;

    logic           in_idle, in_xfer, in_drain;
    logic           byte_hs, data_pop, last_pop;

    assign desc                 = tti_tx_desc_queue_rdata_i;
    assign unused_desc_reserved = ^desc.reserved;

    // Qualifying with rst_ni keeps every output low while reset is held, including the
    // descriptor pop that IDLE would otherwise advertise.
    assign in_idle  = rst_ni && (state_q == IDLE);
    assign in_xfer  = rst_ni && (state_q == XFER);
    assign in_drain = rst_ni && (state_q == DRAIN);

    assign byte_hs  = in_xfer && tx_byte_ready_i && tti_tx_queue_rvalid_i;
    assign data_pop = byte_hs || (in_drain && tti_tx_queue_rvalid_i);
    assign last_pop = data_pop && (remaining_q == 16'd1);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tti_tx_desc_queue_rvalid_i) begin
                    remaining_d = desc.data_length;
                    if (desc.data_length != 16'd0) begin
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                // A final handshake wins over a coincident abort: nothing is left to drain.
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tx_abort_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (data_pop && (remaining_q != 16'd0)) begin
            remaining_d = remaining_q - 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            remaining_q <= 16'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    assign tti_tx_desc_queue_rready_o = in_idle;
    assign tti_tx_queue_rready_o      = data_pop;

    assign tx_byte_o         = in_xfer ? tti_tx_queue_rdata_i[7:0] : 8'h00;
    assign tx_byte_valid_o   = in_xfer && tti_tx_queue_rvalid_i;
    assign tx_byte_last_o    = tx_byte_valid_o && (remaining_q == 16'd1);
    assign tx_byte_err_o     = in_xfer && tx_byte_ready_i && !tti_tx_queue_rvalid_i;
    assign tx_data_pending_o = in_xfer;
    assign tx_done_o         = done_q;

endmodule

// File: tb/tb_descriptor_tx.sv
// Self-checking bench for descriptor_tx: queue-backed environment, per-cycle reference model,
// directed scenarios with literal expectations, then randomized descriptor traffic.
module tb_descriptor_tx;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        desc_rvalid, desc_rready;
    logic [31:0] desc_rdata;
    logic        q_rvalid, q_rready;
    logic [7:0]  q_rdata;
    logic [7:0]  tx_byte;
    logic        tx_valid, tx_ready, tx_last, tx_err, tx_abort, tx_pending, tx_done;

    always #5 clk_i = ~clk_i;

    descriptor_tx dut (
        .clk_i                      (clk_i),
        .rst_ni                     (rst_ni),
        .tti_tx_desc_queue_rvalid_i (desc_rvalid),
        .tti_tx_desc_queue_rready_o (desc_rready),
        .tti_tx_desc_queue_rdata_i  (desc_rdata),
        .tti_tx_queue_rvalid_i      (q_rvalid),
        .tti_tx_queue_rready_o      (q_rready),
        .tti_tx_queue_rdata_i       (q_rdata),
        .tx_byte_o                  (tx_byte),
        .tx_byte_valid_o            (tx_valid),
        .tx_byte_ready_i            (tx_ready),
        .tx_byte_last_o             (tx_last),
        .tx_byte_err_o              (tx_err),
        .tx_abort_i                 (tx_abort),
        .tx_data_pending_o          (tx_pending),
        .tx_done_o                  (tx_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Environment: the two TTI queues, owned by the bench.
    logic [31:0] desc_q[$];
    logic [7:0]  data_q[$];
    bit          drv_ready = 1'b0;
    bit          drv_abort = 1'b0;
    bit          drv_gate  = 1'b1;

    // Reference model: is a descriptor loaded, is it being discarded, bytes still owed.
    bit          m_active = 1'b0;
    bit          m_drain  = 1'b0;
    bit          m_done   = 1'b0;
    int          m_left   = 0;

    // Per-cycle samples and the stream seen by the target FSM.
    logic        s_valid, s_err, s_done;
    logic [7:0]  log_byte[$];
    bit          log_last[$];
    int          done_cnt = 0;

    task automatic tick();
        bit e_xfer, e_drain, e_valid, e_qrdy;
        bit desc_pop, data_pop;
        int len;
        @(negedge clk_i);
        desc_rvalid = (desc_q.size() > 0);
        desc_rdata  = desc_rvalid ? desc_q[0] : $urandom;
        q_rvalid    = drv_gate && (data_q.size() > 0);
        q_rdata     = (data_q.size() > 0) ? data_q[0] : 8'($urandom);
        tx_ready    = drv_ready;
        tx_abort    = drv_abort;
        #1;
        e_xfer  = rst_ni && m_active && !m_drain;
        e_drain = rst_ni && m_active && m_drain;
        e_valid = e_xfer && q_rvalid;
        e_qrdy  = e_xfer ? (tx_ready && q_rvalid) : (e_drain && q_rvalid);

        check("desc_rready", desc_rready, rst_ni && !m_active);
        check("data_rready", q_rready, e_qrdy);
        check("tx_byte",     tx_byte, e_xfer ? q_rdata : 8'h00);
        check("tx_valid",    tx_valid, e_valid);
        check("tx_last",     tx_last, e_valid && (m_left == 1));
        check("tx_err",      tx_err, e_xfer && tx_ready && !q_rvalid);
        check("tx_pending",  tx_pending, e_xfer);
        check("tx_done",     tx_done, rst_ni && m_done);

        s_valid  = tx_valid;
        s_err    = tx_err;
        s_done   = tx_done;
        desc_pop = desc_rvalid && desc_rready;
        data_pop = q_rvalid && q_rready;
        if (tx_valid && tx_ready) begin
            log_byte.push_back(tx_byte);
            log_last.push_back(tx_last);
        end
        if (tx_done) done_cnt++;

        @(posedge clk_i);
        if (desc_pop) void'(desc_q.pop_front());
        if (data_pop) void'(data_q.pop_front());

        m_done = 1'b0;
        if (!rst_ni) begin
            m_active = 1'b0;
            m_drain  = 1'b0;
            m_left   = 0;
        end else if (!m_active) begin
            if (desc_rvalid) begin
                len = int'(desc_rdata[15:0]);
                if (len != 0) begin
                    m_active = 1'b1;
                    m_left   = len;
                end
            end
        end else if (!m_drain) begin
            if (tx_ready && q_rvalid) m_left--;
            if (m_left == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else if (tx_abort) begin
                m_drain = 1'b1;
            end
        end else if (q_rvalid) begin
            m_left--;
            if (m_left == 0) begin
                m_active = 1'b0;
                m_drain  = 1'b0;
                m_done   = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < max_cycles) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, done_cnt > start, 1);
    endtask

    task automatic push_desc(input logic [15:0] len);
        desc_q.push_back({16'($urandom), len});
    endtask

    task automatic clear_log();
        log_byte.delete();
        log_last.delete();
    endtask

    initial begin
        int start;
        int n;

        // Reset state.
        repeat (2) tick();
        #2 rst_ni = 1'b1;
        tick();
        check("reset_idle_pending", s_valid, 0);

        // 1: three bytes in order, last on the third, one done pulse.
        clear_log();
        start = done_cnt;
        drv_ready = 1'b1;
        push_desc(16'd3);
        data_q.push_back(8'hA1); data_q.push_back(8'hB2); data_q.push_back(8'hC3);
        wait_done("t1", 20);
        check("t1_count", log_byte.size(), 3);
        if (log_byte.size() == 3) begin
            check("t1_b0", log_byte[0], 8'hA1);
            check("t1_b1", log_byte[1], 8'hB2);
            check("t1_b2", log_byte[2], 8'hC3);
            check("t1_last", {log_last[0], log_last[1], log_last[2]}, 3'b001);
        end
        tick();
        check("t1_done_once", done_cnt - start, 1);

        // 2: underflow raises err with valid low until data arrives.
        clear_log();
        push_desc(16'd4);
        data_q.push_back(8'h01); data_q.push_back(8'h02);
        repeat (4) tick();
        check("t2_err", s_err, 1);
        check("t2_valid", s_valid, 0);
        data_q.push_back(8'h03); data_q.push_back(8'h04);
        wait_done("t2", 20);
        check("t2_count", log_byte.size(), 4);
        if (log_byte.size() == 4) begin
            check("t2_b3", log_byte[3], 8'h04);
            check("t2_last", {log_last[0], log_last[1], log_last[2], log_last[3]}, 4'b0001);
        end

        // 3: abort after two bytes drains the other three; next descriptor starts clean.
        clear_log();
        start = done_cnt;
        push_desc(16'd5);
        for (int i = 0; i < 5; i++) data_q.push_back(8'h30 + 8'(i));
        push_desc(16'd1);
        data_q.push_back(8'h5A);
        repeat (3) tick();
        drv_ready = 1'b0;
        drv_abort = 1'b1;
        tick();
        drv_abort = 1'b0;
        drv_ready = 1'b1;
        wait_done("t3_drain", 20);
        check("t3_sent", log_byte.size(), 2);
        check("t3_left_in_queue", data_q.size(), 1);
        wait_done("t3_next", 20);
        check("t3_next_count", log_byte.size(), 3);
        if (log_byte.size() == 3) check("t3_next_byte", log_byte[2], 8'h5A);
        check("t3_done_twice", done_cnt - start, 2);

        // 4: abort on the final handshake completes normally, queue untouched afterwards.
        clear_log();
        push_desc(16'd2);
        data_q.push_back(8'h11); data_q.push_back(8'h22); data_q.push_back(8'hEE);
        repeat (2) tick();
        drv_abort = 1'b1;
        tick();
        drv_abort = 1'b0;
        tick();
        check("t4_done", s_done, 1);
        repeat (3) tick();
        check("t4_queue_untouched", data_q.size(), 1);
        push_desc(16'd1);
        wait_done("t4_next", 20);
        check("t4_count", log_byte.size(), 3);
        if (log_byte.size() == 3) check("t4_next_byte", log_byte[2], 8'hEE);

        // 5: zero-length descriptor consumed silently, then a single-byte one.
        clear_log();
        start = done_cnt;
        desc_q.push_back(32'hABCD_0000);
        push_desc(16'd1);
        data_q.push_back(8'h77);
        wait_done("t5", 20);
        tick();
        check("t5_done_once", done_cnt - start, 1);
        check("t5_count", log_byte.size(), 1);
        if (log_byte.size() == 1) begin
            check("t5_byte", log_byte[0], 8'h77);
            check("t5_last", log_last[0], 1);
        end

        // 6: reset mid-transfer clears outputs at once; bytes stay queued for the next descriptor.
        clear_log();
        push_desc(16'd5);
        for (int i = 0; i < 5; i++) data_q.push_back(8'h60 + 8'(i));
        repeat (3) tick();
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst_pending", tx_pending, 0);
        check("t6_rst_desc_rready", desc_rready, 0);
        check("t6_rst_data_rready", q_rready, 0);
        check("t6_rst_valid", tx_valid, 0);
        tick();
        #2 rst_ni = 1'b1;
        check("t6_queue_kept", data_q.size(), 3);
        push_desc(16'd3);
        wait_done("t6", 20);
        check("t6_count", log_byte.size(), 5);
        if (log_byte.size() == 5) begin
            check("t6_b2", log_byte[2], 8'h62);
            check("t6_b4", log_byte[4], 8'h64);
            check("t6_last", log_last[4], 1);
        end

        // Randomized traffic: underflow, back-pressure and aborts in any state.
        for (int d = 0; d < 30; d++) begin
            int len = $urandom_range(0, 6);
            push_desc(16'(len));
            for (int i = 0; i < len; i++) data_q.push_back(8'($urandom));
        end
        n = 0;
        while ((desc_q.size() > 0 || data_q.size() > 0 || m_active || m_done) && n < 3000) begin
            drv_ready = ($urandom_range(0, 9) < 7);
            drv_gate  = ($urandom_range(0, 9) < 8);
            drv_abort = ($urandom_range(0, 99) < 4);
            tick();
            n++;
        end
        check("random_completed", n < 3000, 1);
        drv_abort = 1'b0;
        drv_gate  = 1'b1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
